lms_stim_gen: RTL

LMS_STIM_GEN -- requirements
Module: lms_stim_gen

---
 rtl/lms_stim_gen.sv | 131 +++++++++++++
 1 files changed

// File: rtl/lms_stim_gen.sv
// Stimulus generator for an LMS adaptive filter: produces x samples (LFSR or external)
// and the matching output of a programmable L-tap FIR reference plant.
module lms_stim_gen #(
    parameter int W1 = 12,
    parameter int W2 = 32,
    parameter int L  = 16,
    parameter int CW = 16,
    localparam int AW = (L > 1) ? $clog2(L) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 x_sel,
    input  logic signed [W1-1:0] x_ext,
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic                 coef_err,
    output logic signed [W1-1:0] x_out,
    output logic signed [W2-1:0] d_out,
    output logic                 valid_out,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    // Handshake: valid_out is a one-cycle strobe with no back-pressure; x_out/d_out
    // change only on the cycle valid_out is high and hold until the next strobe.

    typedef enum logic [1:0] {IDLE, SHIFT, MAC, OUT} state_t;

    localparam logic [15:0] SEED = 16'hACE1;

    state_t                state_q, state_d;
    logic [15:0]           lfsr_q, lfsr_d, lfsr_adv;
    logic signed [W1-1:0]  xd_q [L];
    logic signed [CW-1:0]  c_q  [L];
    logic signed [W2-1:0]  acc_q, acc_d;
    logic [AW-1:0]         k_q, k_d;
    logic signed [W1-1:0]  x_out_q, x_out_d;
    logic signed [W2-1:0]  d_out_q, d_out_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  shift_en;
    logic                  coef_wr;
    logic signed [W1-1:0]  x_new;
    logic signed [W1+CW-1:0] prod;

    // Taps 16,14,13,11; an all-zero state would lock up, so it is reseeded.
    assign lfsr_adv = (lfsr_q == 16'h0) ? SEED
                    : {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // The LFSR source assumes W1 <= 16.
    assign x_new   = x_sel ? x_ext : lfsr_q[W1-1:0];
    assign prod    = c_q[k_q] * xd_q[k_q];
    assign coef_wr = coef_we && (state_q == IDLE);

    always_comb begin
        state_d  = state_q;
        lfsr_d   = (lfsr_q == 16'h0) ? SEED : lfsr_q;
        acc_d    = acc_q;
        k_d      = k_q;
        x_out_d  = x_out_q;
        d_out_d  = d_out_q;
        valid_d  = 1'b0;
        err_d    = coef_we && (state_q != IDLE);
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) state_d = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (!x_sel) lfsr_d = lfsr_adv;
                acc_d   = '0;
                k_d     = '0;
                state_d = MAC;
            end
            MAC: begin
                acc_d = acc_q + W2'(prod);
                if (k_q == AW'(L - 1)) state_d = OUT;
                else                   k_d     = k_q + AW'(1);
            end
            OUT: begin
                x_out_d = xd_q[0];
                d_out_d = acc_q;
                valid_d = 1'b1;
                state_d = run ? SHIFT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            acc_q   <= '0;
            k_q     <= '0;
            x_out_q <= '0;
            d_out_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < L; i++) begin
                xd_q[i] <= '0;
                c_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            x_out_q <= x_out_d;
            d_out_q <= d_out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            if (shift_en) begin
                for (int i = L - 1; i > 0; i--) xd_q[i] <= xd_q[i-1];
                xd_q[0] <= x_new;
            end
            if (coef_wr) c_q[coef_addr] <= coef_data;
        end
    end

    assign x_out     = x_out_q;
    assign d_out     = d_out_q;
    assign valid_out = valid_q;
    assign coef_err  = err_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule
